jtag_tap: RTL and testbench
===========================

JTAG_TAP -- requirements
Module: jtag_tap

Interface
REQ-001 Parameter IDCODE_VAL, default 32'h1000_0DB3, value captured into the IDCODE data register (bit 0 SHALL be 1).
REQ-002 Parameter IR_LEN, default 5, instruction register width.
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer depth for tck_i/tms_i/tdi_i.
REQ-004 clk_i  in  1  system clock; single clock domain.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 tck_i  in  1  JTAG TCK from jtag_master, treated as data and oversampled; frequency SHALL be <= clk_i/6.
REQ-007 tms_i  in  1  JTAG TMS.
REQ-008 tdi_i  in  1  JTAG TDI.
REQ-009 tdo_o  out  1  JTAG TDO.
REQ-010 tdo_oe_o  out  1  high only in Shift-IR/Shift-DR.
REQ-011 tap_state_o  out  4  current TAP state (package encoding), for debug/bench.
REQ-012 ir_o  out  IR_LEN  current (updated) instruction.

Function
REQ-013 tck_i, tms_i and tdi_i SHALL each pass through SYNC_STAGES flops; one further flop on the synced tck SHALL give rise/fall strobes, each one clk_i cycle wide.
REQ-014 On a rise strobe the TAP SHALL sample synced TMS/TDI, perform the current state's shift/capture action and advance the 16-state IEEE 1149.1 FSM in that same clk_i cycle.
REQ-015 FSM states: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR; transitions per standard TMS table.
REQ-016 Five consecutive rise strobes with TMS=1 SHALL reach TLR from any state.
REQ-017 CapIR SHALL load the IR shift register with {IR_LEN-2 zeros, 2'b01}.
REQ-018 ShIR SHALL shift right, TDI into MSB; UpdIR SHALL copy the shift register to ir_o.
REQ-019 Instructions: IDCODE = 5'h01, BYPASS = 5'h1F; every other code SHALL select BYPASS.
REQ-020 CapDR with IDCODE SHALL load IDCODE_VAL into a 32-bit shift register; with BYPASS SHALL load 0 into the 1-bit bypass register.
REQ-021 ShDR SHALL shift the selected DR right, TDI into MSB; the IDCODE DR SHALL NOT be writable at UpdDR.
REQ-022 On a fall strobe, tdo_o SHALL register the LSB of the selected shift register (IR in ShIR, DR in ShDR); outside shift states tdo_o SHALL hold 0.
REQ-023 Shifting more than 32 bits through IDCODE SHALL return TDI bits delayed by 32 TCKs (no wrap of IDCODE_VAL).
REQ-024 Entering TLR (via TMS or reset) SHALL set ir_o to IDCODE.
REQ-025 Rise and fall strobes cannot coincide given REQ-006; no behaviour is defined for tck faster than clk_i/6.

Reset
REQ-026 While rst_i is high at a clk_i edge: state = TLR, ir_o = 5'h01, all shift registers = 0, sync/edge flops = 0, tdo_o = 0, tdo_oe_o = 0.
REQ-027 Reset asserted mid-shift SHALL abort the scan; no partial IR update SHALL occur.
REQ-028 The first rise strobe SHALL be detectable no earlier than SYNC_STAGES+1 cycles after rst_i deasserts.

Structure
REQ-029 A shared package jtag_pkg SHALL hold the tap_state_e enum (4-bit), IR_IDCODE, IR_BYPASS and IDCODE_LEN=32.
REQ-030 The synchronizer-plus-edge-detect SHALL be one sub-module, jtag_sync_edge, instantiated once per input bundle.

Verification
REQ-031 rst_i 2 cycles, then 5 TCKs TMS=1 -> tap_state_o = TLR, ir_o = 5'h01.
REQ-032 After reset, TMS 0,1,0,0 then 32 TCKs in ShDR -> tdo_o stream LSB-first equals 32'h1000_0DB3.
REQ-033 Shift IR 5'h1F, UpdIR, then ShDR with TDI pattern 1,0,1,1 -> tdo_o = 0,1,0,1 (1-bit bypass delay).
REQ-034 ShIR with TDI = 5'b00000 -> first 5 tdo_o bits = 1,0,0,0,0 (captured 5'b00001).
REQ-035 rst_i pulsed after 10 bits of IDCODE shift -> state TLR, tdo_oe_o = 0, subsequent IDCODE read returns 32'h1000_0DB3.
REQ-036 Unknown IR 5'h07 loaded -> DR path length 1 (bypass behaviour as REQ-033).

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions.
// Holds the 4-bit TAP state encoding, the instruction codes and the IDCODE
// data register length used by the TAP and by anything observing tap_state_o.
package jtag_pkg;

    localparam int         IDCODE_LEN = 32;
    localparam logic [4:0] IR_IDCODE  = 5'h01;
    localparam logic [4:0] IR_BYPASS  = 5'h1F;

    typedef enum logic [3:0] {
        TLR      = 4'd0,
        RTI      = 4'd1,
        SEL_DR   = 4'd2,
        CAP_DR   = 4'd3,
        SH_DR    = 4'd4,
        EX1_DR   = 4'd5,
        PAUSE_DR = 4'd6,
        EX2_DR   = 4'd7,
        UPD_DR   = 4'd8,
        SEL_IR   = 4'd9,
        CAP_IR   = 4'd10,
        SH_IR    = 4'd11,
        EX1_IR   = 4'd12,
        PAUSE_IR = 4'd13,
        EX2_IR   = 4'd14,
        UPD_IR   = 4'd15
    } tap_state_e;

endpackage

// File: rtl/jtag_sync_edge.sv
// Oversampling synchronizer for one JTAG input bundle.
// Ports:
//   clk_i, rst_i   system clock, synchronous active-high reset
//   i_tck          asynchronous TCK
//   i_data         asynchronous companion signals (e.g. {TMS, TDI})
//   o_data         synchronized companion signals
//   o_rise, o_fall one-clk_i-wide strobes on synchronized TCK edges
// TCK and its companions go through the same number of stages, so o_data is
// aligned with the strobe that marks the TCK edge.
module jtag_sync_edge #(
    parameter int W           = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         i_tck,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_rise,
    output logic         o_fall
);

    // Bit 0 carries TCK, the upper bits carry i_data.
    logic [W:0] r_sync [SYNC_STAGES];
    logic       r_tck_d;
    logic       w_tck_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_tck_d <= 1'b0;
        end else begin
            r_sync[0] <= {i_data, i_tck};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_tck_d <= w_tck_s;
        end
    end

    assign w_tck_s = r_sync[SYNC_STAGES-1][0];
    assign o_data  = r_sync[SYNC_STAGES-1][W:1];
    assign o_rise  = w_tck_s & ~r_tck_d;
    assign o_fall  = ~w_tck_s & r_tck_d;

endmodule

// File: rtl/jtag_tap.sv
// IEEE 1149.1 TAP controller clocked by the system clock.
// TCK/TMS/TDI are oversampled; all TAP activity happens on the clk_i cycle
// carrying a synchronized TCK edge strobe.
// Ports:
//   clk_i, rst_i   system clock, synchronous active-high reset
//   tck_i, tms_i, tdi_i  JTAG inputs (asynchronous, TCK <= clk_i/6)
//   tdo_o          JTAG TDO, updated on TCK falling edges
//   tdo_oe_o       high while in Shift-IR or Shift-DR
//   tap_state_o    current TAP state (jtag_pkg encoding)
//   ir_o           current (updated) instruction
// Instructions: IDCODE selects the 32-bit IDCODE register, every other code
// selects the 1-bit bypass register.
module jtag_tap
    import jtag_pkg::*;
#(
    parameter logic [31:0] IDCODE_VAL  = 32'h1000_0DB3,
    parameter int          IR_LEN      = 5,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tck_i,
    input  logic              tms_i,
    input  logic              tdi_i,
    output logic              tdo_o,
    output logic              tdo_oe_o,
    output logic [3:0]        tap_state_o,
    output logic [IR_LEN-1:0] ir_o
);

    localparam logic [IR_LEN-1:0] IR_RESET   = IR_LEN'(IR_IDCODE);
    localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(2'b01);

    logic [1:0]            w_sync;
    logic                  w_tms;
    logic                  w_tdi;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_shift;
    logic                  w_sel_id;
    tap_state_e            r_state;
    tap_state_e            w_next;
    logic [IR_LEN-1:0]     r_ir;
    logic [IR_LEN-1:0]     r_ir_sr;
    logic [IDCODE_LEN-1:0] r_dr_id;
    logic                  r_bypass;
    logic                  r_tdo;

    jtag_sync_edge #(
        .W           (2),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_tck  (tck_i),
        .i_data ({tms_i, tdi_i}),
        .o_data (w_sync),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_tms    = w_sync[1];
    assign w_tdi    = w_sync[0];
    assign w_shift  = (r_state == SH_IR) || (r_state == SH_DR);
    assign w_sel_id = (r_ir == IR_RESET);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= TLR;
        end else if (w_rise) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            TLR:      w_next = w_tms ? TLR    : RTI;
            RTI:      w_next = w_tms ? SEL_DR : RTI;
            SEL_DR:   w_next = w_tms ? SEL_IR : CAP_DR;
            CAP_DR:   w_next = w_tms ? EX1_DR : SH_DR;
            SH_DR:    w_next = w_tms ? EX1_DR : SH_DR;
            EX1_DR:   w_next = w_tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: w_next = w_tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   w_next = w_tms ? UPD_DR : SH_DR;
            UPD_DR:   w_next = w_tms ? SEL_DR : RTI;
            SEL_IR:   w_next = w_tms ? TLR    : CAP_IR;
            CAP_IR:   w_next = w_tms ? EX1_IR : SH_IR;
            SH_IR:    w_next = w_tms ? EX1_IR : SH_IR;
            EX1_IR:   w_next = w_tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: w_next = w_tms ? EX2_IR : PAUSE_IR;
            EX2_IR:   w_next = w_tms ? UPD_IR : SH_IR;
            UPD_IR:   w_next = w_tms ? SEL_DR : RTI;
            default:  w_next = TLR;
        endcase
    end

    // Actions belong to the state being left on this rise strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ir     <= IR_RESET;
            r_ir_sr  <= '0;
            r_dr_id  <= '0;
            r_bypass <= 1'b0;
        end else if (w_rise) begin
            case (r_state)
                CAP_IR: r_ir_sr <= IR_CAPTURE;
                SH_IR:  r_ir_sr <= {w_tdi, r_ir_sr[IR_LEN-1:1]};
                UPD_IR: r_ir    <= r_ir_sr;
                CAP_DR: begin
                    if (w_sel_id) begin
                        r_dr_id <= IDCODE_VAL;
                    end else begin
                        r_bypass <= 1'b0;
                    end
                end
                SH_DR: begin
                    if (w_sel_id) begin
                        r_dr_id <= {w_tdi, r_dr_id[IDCODE_LEN-1:1]};
                    end else begin
                        r_bypass <= w_tdi;
                    end
                end
                default: ;
            endcase
            if (w_next == TLR) begin
                r_ir <= IR_RESET;
            end
        end
    end

    // TDO is forced low as soon as the TAP leaves a shift state.
    always_ff @(posedge clk_i) begin
        if (rst_i || !w_shift) begin
            r_tdo <= 1'b0;
        end else if (w_fall) begin
            if (r_state == SH_IR) begin
                r_tdo <= r_ir_sr[0];
            end else begin
                r_tdo <= w_sel_id ? r_dr_id[0] : r_bypass;
            end
        end
    end

    assign tdo_o       = r_tdo;
    assign tdo_oe_o    = w_shift;
    assign tap_state_o = r_state;
    assign ir_o        = r_ir;

endmodule

// File: tb/tb_jtag_tap.sv
// Directed bench for jtag_tap with a TCK-level behavioural model.
// The model walks a TMS transition table and treats every register as a
// bit queue (LSB at the front); a compare process checks all outputs at the
// end of every TCK half period, and directed scans are checked against
// hand-computed literals.
module tb_jtag_tap;
    import jtag_pkg::*;

    localparam logic [31:0] IDCODE = 32'h1000_0DB3;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       tck_i;
    logic       tms_i;
    logic       tdi_i;
    logic       tdo_o;
    logic       tdo_oe_o;
    logic [3:0] tap_state_o;
    logic [4:0] ir_o;

    jtag_tap #(
        .IDCODE_VAL  (IDCODE),
        .IR_LEN      (5),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .tck_i       (tck_i),
        .tms_i       (tms_i),
        .tdi_i       (tdi_i),
        .tdo_o       (tdo_o),
        .tdo_oe_o    (tdo_oe_o),
        .tap_state_o (tap_state_o),
        .ir_o        (ir_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;
    event chk_ev;

    // Behavioural model
    tap_state_e NXT0 [16] = '{RTI, RTI, CAP_DR, SH_DR, SH_DR, PAUSE_DR, PAUSE_DR, SH_DR,
                              RTI, CAP_IR, SH_IR, SH_IR, PAUSE_IR, PAUSE_IR, SH_IR, RTI};
    tap_state_e NXT1 [16] = '{TLR, SEL_DR, SEL_IR, EX1_DR, EX1_DR, UPD_DR, EX2_DR, UPD_DR,
                              SEL_DR, TLR, EX1_IR, EX1_IR, UPD_IR, EX2_IR, UPD_IR, SEL_DR};
    tap_state_e m_st;
    logic [4:0] m_ir;
    logic       m_tdo;
    logic       iq[$];
    logic       dq[$];

    task automatic m_reset();
        m_st  = TLR;
        m_ir  = 5'h01;
        m_tdo = 1'b0;
        iq    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        dq    = '{1'b0};
    endtask

    task automatic m_rise(input logic tms, input logic tdi);
        case (m_st)
            CAP_IR: iq = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            SH_IR: begin
                void'(iq.pop_front());
                iq.push_back(tdi);
            end
            UPD_IR: for (int i = 0; i < 5; i++) m_ir[i] = iq[i];
            CAP_DR: begin
                dq.delete();
                if (m_ir == 5'h01) begin
                    for (int i = 0; i < 32; i++) dq.push_back(IDCODE[i]);
                end else begin
                    dq.push_back(1'b0);
                end
            end
            SH_DR: begin
                void'(dq.pop_front());
                dq.push_back(tdi);
            end
            default: ;
        endcase
        m_st = tms ? NXT1[m_st] : NXT0[m_st];
        if (m_st == TLR) m_ir = 5'h01;
        if (m_st != SH_IR && m_st != SH_DR) m_tdo = 1'b0;
    endtask

    task automatic m_fall();
        if (m_st == SH_IR)      m_tdo = iq[0];
        else if (m_st == SH_DR) m_tdo = dq[0];
        else                    m_tdo = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Compare process
    always @(chk_ev) begin
        chk("state", 32'(tap_state_o), 32'(m_st));
        chk("ir", 32'(ir_o), 32'(m_ir));
        chk("tdo", 32'(tdo_o), 32'(m_tdo));
        chk("tdo_oe", 32'(tdo_oe_o), 32'((m_st == SH_IR) || (m_st == SH_DR)));
    end

    task automatic half_wait();
        repeat (5) @(negedge clk_i);
        -> chk_ev;
        #1;
    endtask

    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo_s);
        tms_i = tms;
        tdi_i = tdi;
        half_wait();
        tdo_s = tdo_o;
        tck_i = 1'b1;
        m_rise(tms, tdi);
        half_wait();
        tck_i = 1'b0;
        m_fall();
    endtask

    task automatic tms_seq(input int n, input logic [15:0] s);
        logic b;
        for (int i = 0; i < n; i++) tck_cycle(s[i], 1'b0, b);
    endtask

    task automatic scan(input int n, input logic [63:0] tv, output logic [63:0] ov);
        logic b;
        ov = '0;
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, tv[i], b);
            ov[i] = b;
        end
    endtask

    task automatic do_reset(input int cyc);
        rst_i = 1'b1;
        repeat (cyc) @(negedge clk_i);
        m_reset();
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        -> chk_ev;
        #1;
    endtask

    initial begin
        logic [63:0] ov;
        logic        b;
        tck_i = 1'b0;
        tms_i = 1'b1;
        tdi_i = 1'b0;
        rst_i = 1'b1;
        m_reset();
        @(negedge clk_i);

        do_reset(2);
        chk("rst_state", 32'(tap_state_o), 32'(TLR));
        chk("rst_ir", 32'(ir_o), 32'h01);
        chk("rst_oe", 32'(tdo_oe_o), 32'h0);
        tms_seq(5, 16'h1F);
        chk("tlr_state", 32'(tap_state_o), 32'(TLR));
        chk("tlr_ir", 32'(ir_o), 32'h01);

        // IDCODE readout
        tms_seq(4, 16'b0010);
        chk("enter_shdr", 32'(tap_state_o), 32'(SH_DR));
        scan(32, 64'h0, ov);
        chk("idcode", ov[31:0], 32'h1000_0DB3);
        tms_seq(2, 16'b01);

        // IR = 1F then bypass
        tms_seq(4, 16'b0011);
        scan(5, 64'h1F, ov);
        chk("ir_capture_1f", 32'(ov[4:0]), 32'h01);
        tms_seq(2, 16'b01);
        chk("ir_1f", 32'(ir_o), 32'h1F);
        tms_seq(3, 16'b001);
        scan(4, 64'b1101, ov);
        chk("bypass_1f", 32'(ov[3:0]), 32'b1010);
        tms_seq(2, 16'b01);

        // Unknown IR 07 behaves as bypass
        tms_seq(4, 16'b0011);
        scan(5, 64'h07, ov);
        chk("ir_capture_07", 32'(ov[4:0]), 32'h01);
        tms_seq(2, 16'b01);
        chk("ir_07", 32'(ir_o), 32'h07);
        tms_seq(3, 16'b001);
        scan(4, 64'b0110, ov);
        chk("bypass_07", 32'(ov[3:0]), 32'b1100);
        tms_seq(2, 16'b01);

        // IR shift of zeros still returns the captured pattern
        tms_seq(4, 16'b0011);
        scan(5, 64'h00, ov);
        chk("ir_capture_00", 32'(ov[4:0]), 32'h01);
        tms_seq(2, 16'b01);
        chk("ir_00", 32'(ir_o), 32'h00);

        // TMS reset restores IDCODE, then reset mid-scan
        tms_seq(5, 16'h1F);
        chk("tms_reset_ir", 32'(ir_o), 32'h01);
        tms_seq(4, 16'b0010);
        for (int i = 0; i < 10; i++) tck_cycle(1'b0, 1'b1, b);
        do_reset(2);
        chk("midrst_state", 32'(tap_state_o), 32'(TLR));
        chk("midrst_oe", 32'(tdo_oe_o), 32'h0);
        chk("midrst_ir", 32'(ir_o), 32'h01);
        tms_seq(4, 16'b0010);
        scan(32, 64'h0, ov);
        chk("idcode_after_rst", ov[31:0], 32'h1000_0DB3);
        tms_seq(2, 16'b01);

        // 40-bit shift: TDI emerges 32 TCKs later
        tms_seq(3, 16'b001);
        scan(40, 64'hC5, ov);
        chk("idcode_long", ov[31:0], 32'h1000_0DB3);
        chk("idcode_delay", 32'(ov[39:32]), 32'hC5);
        tms_seq(2, 16'b01);
        chk("final_state", 32'(tap_state_o), 32'(RTI));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
